// File: rtl/cpu32_mem_pkg.sv
// Shared definitions for the CPU32 memory-port arbiter: FSM state encoding
// and the default bus widths and timing limits.
package cpu32_mem_pkg;

  localparam int AW_DEF           = 32;
  localparam int DW_DEF           = 32;
  localparam int TIMEOUT_DEF      = 255;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-side signals of the shared CPU32 memory port.
// The master modport is the arbiter's view; slave is the core/memory side.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          if_err;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_valid;
  logic [DW-1:0] d_rdata;
  logic          d_err;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  logic          busy;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_valid, if_rdata, if_err,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_valid, d_rdata, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output busy
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_valid, if_rdata, if_err,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_valid, d_rdata, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  busy
  );

endinterface

// File: rtl/mem_arb_timer.sv
// Timeout counter for an outstanding memory transaction: cleared on accept,
// counts while enabled, flags the edge on which the timeout limit is reached.
module mem_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] cnt;

  // tc is asserted on the TIMEOUT-th enabled edge after a clear
  assign tc = en && (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the CPU32 memory/ROM port between instruction fetch and the LSU,
// one transaction at a time, with data priority, fetch anti-starvation and timeout.
module mem_port_arbiter
  import cpu32_mem_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.master bus
);

  arb_state_t state;
  logic [3:0] starve_cnt;
  logic       idle;
  logic       d_pri;
  logic       if_win;
  logic       d_win;
  logic       tmo_tc;

  assign idle = (state == IDLE);

  // data wins unless fetch has lost STARVE_LIMIT times in a row
  assign d_pri  = bus.d_req && (starve_cnt < 4'(STARVE_LIMIT));
  assign if_win = idle && bus.if_req && !d_pri;
  assign d_win  = idle && bus.d_req && (d_pri || !bus.if_req);

  assign bus.if_gnt = if_win;
  assign bus.d_gnt  = d_win;
  assign bus.busy   = !idle;

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (if_win || d_win),
    .en  (!idle),
    .tc  (tmo_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_valid  <= 1'b0;
      bus.if_rdata  <= '0;
      bus.if_err    <= 1'b0;
      bus.d_valid   <= 1'b0;
      bus.d_rdata   <= '0;
      bus.d_err     <= 1'b0;
    end else begin
      bus.if_valid <= 1'b0;
      bus.d_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_win) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.if_addr;
            bus.mem_wdata <= '0;
            starve_cnt    <= '0;
            state         <= BUSY_I;
          end else if (d_win) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.d_we;
            bus.mem_addr  <= bus.d_addr;
            bus.mem_wdata <= bus.d_wdata;
            if (bus.if_req && starve_cnt != 4'hF) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
            state <= BUSY_D;
          end
        end
        BUSY_I: begin
          // an ack on the terminal-count edge still completes normally
          if (bus.mem_ack) begin
            bus.mem_req  <= 1'b0;
            bus.if_valid <= 1'b1;
            bus.if_rdata <= bus.mem_rdata;
            bus.if_err   <= 1'b0;
            state        <= IDLE;
          end else if (tmo_tc) begin
            bus.mem_req  <= 1'b0;
            bus.if_valid <= 1'b1;
            bus.if_rdata <= '0;
            bus.if_err   <= 1'b1;
            state        <= IDLE;
          end
        end
        BUSY_D: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            bus.d_valid <= 1'b1;
            bus.d_rdata <= bus.mem_we ? '0 : bus.mem_rdata;
            bus.d_err   <= 1'b0;
            state       <= IDLE;
          end else if (tmo_tc) begin
            bus.mem_req <= 1'b0;
            bus.d_valid <= 1'b1;
            bus.d_rdata <= '0;
            bus.d_err   <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model drives a
// scoreboard of expected completions; a monitor checks every valid pulse.
module tb_mem_port_arbiter;

  localparam int TO = 8;
  localparam int SL = 4;

  typedef struct {
    bit          side;   // 1 = data, 0 = fetch
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(
    .AW           (32),
    .DW           (32),
    .STARVE_LIMIT (SL),
    .TIMEOUT      (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  // reference model state
  bit          m_busy = 0;
  bit          m_side = 0;
  int          m_cnt = 0;
  int          m_delay = 0;
  logic [31:0] m_data = 0;
  logic [31:0] m_addr = 0;
  bit          m_we = 0;
  logic [31:0] m_wdata = 0;
  int          starve = 0;
  bit          exp_vi = 0;
  bit          exp_vd = 0;
  bit          acc_i = 0;
  bit          acc_d = 0;
  bit          spur = 0;
  int          plan_delay = 1;   // 0 = memory never answers
  logic [31:0] plan_data = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h time=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every completion pulse must match the oldest expected response
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst === 1'b1 && (bus.if_valid === 1'b1 || bus.d_valid === 1'b1)) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid actual if_valid=%b d_valid=%b required none", bus.if_valid, bus.d_valid);
      end else begin
        mon_e = sb.pop_front();
        chk("valid_side", 32'(bus.d_valid), 32'(mon_e.side));
        if (mon_e.side) begin
          chk("d_rdata", bus.d_rdata, mon_e.rdata);
          chk("d_err", 32'(bus.d_err), 32'(mon_e.err));
        end else begin
          chk("if_rdata", bus.if_rdata, mon_e.rdata);
          chk("if_err", 32'(bus.if_err), 32'(mon_e.err));
        end
      end
    end
  end

  // One clock of stimulus: called just after a rising edge with inputs set.
  task automatic tick();
    bit   ei, ed, comp, ack, ok;
    exp_t e;
    ei = 0; ed = 0; comp = 0; ack = 0;
    if (!m_busy && rst) begin
      if (bus.d_req && starve < SL) ed = 1;
      else if (bus.if_req)          ei = 1;
      else if (bus.d_req)           ed = 1;
    end
    if (m_busy) begin
      ack  = (m_cnt + 1 == m_delay);
      comp = ack || (m_cnt + 1 == TO);
    end else begin
      ack = spur && ($urandom_range(0, 3) == 0);
    end
    bus.mem_ack   = ack;
    bus.mem_rdata = (m_busy && ack) ? m_data : $urandom;
    @(negedge clk);
    if (rst) begin
      chk("if_gnt", 32'(bus.if_gnt), 32'(ei));
      chk("d_gnt", 32'(bus.d_gnt), 32'(ed));
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("mem_req", 32'(bus.mem_req), 32'(m_busy));
      chk("if_valid", 32'(bus.if_valid), 32'(exp_vi));
      chk("d_valid", 32'(bus.d_valid), 32'(exp_vd));
      if (m_busy) begin
        chk("mem_addr", bus.mem_addr, m_addr);
        chk("mem_we", 32'(bus.mem_we), 32'(m_we));
        if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
      end
    end
    @(posedge clk);
    #1;
    exp_vi = 0; exp_vd = 0;
    acc_i = ei; acc_d = ed;
    if (!rst) begin
      m_busy = 0;
      starve = 0;
      sb.delete();
    end else begin
      if (comp) begin
        m_busy = 0;
        if (m_side) exp_vd = 1;
        else        exp_vi = 1;
      end else if (m_busy) begin
        m_cnt++;
      end
      if (ei || ed) begin
        ok      = (plan_delay >= 1) && (plan_delay <= TO);
        e.side  = ed;
        e.err   = !ok;
        e.rdata = (!ok || (ed && bus.d_we)) ? 32'h0 : plan_data;
        sb.push_back(e);
        m_busy  = 1;
        m_side  = ed;
        m_cnt   = 0;
        m_delay = plan_delay;
        m_data  = plan_data;
        m_addr  = ed ? bus.d_addr : bus.if_addr;
        m_we    = ed && bus.d_we;
        m_wdata = bus.d_wdata;
        if (ei) starve = 0;
        else if (bus.if_req && starve < 15) starve++;
      end
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'h0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'h0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
    chk({tag, "_if_valid"}, 32'(bus.if_valid), 32'h0);
    chk({tag, "_d_valid"}, 32'(bus.d_valid), 32'h0);
    chk({tag, "_if_rdata"}, bus.if_rdata, 32'h0);
    chk({tag, "_d_rdata"}, bus.d_rdata, 32'h0);
    chk({tag, "_if_err"}, 32'(bus.if_err), 32'h0);
    chk({tag, "_d_err"}, 32'(bus.d_err), 32'h0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    tick();
    chk_zero("reset");
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    rst           = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    @(posedge clk);
    #1;
    tick();
    chk_zero("reset");
    rst = 1'b1;

    // single fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h13;
    plan_delay = 1; plan_data = 32'h32E00000;
    tick();
    bus.if_req = 1'b0;
    repeat (3) tick();

    // single store
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h10; bus.d_wdata = 32'hDEADBEAF;
    plan_delay = 2; plan_data = $urandom;
    tick();
    bus.d_req = 1'b0;
    repeat (4) tick();

    // load with no answer, then load answered exactly on the timeout edge
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
    plan_delay = 0; plan_data = 32'h11112222;
    tick();
    bus.d_req = 1'b0;
    repeat (TO + 2) tick();
    bus.d_req = 1'b1; bus.d_addr = 32'h44;
    plan_delay = TO; plan_data = 32'h33334444;
    tick();
    bus.d_req = 1'b0;
    repeat (TO + 2) tick();

    // both requesters saturated: fetch must win every fifth grant
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
    plan_delay = 1;
    repeat (20) begin
      plan_data = $urandom;
      tick();
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    repeat (3) tick();

    // spurious acks while idle
    spur = 1;
    repeat (10) tick();
    spur = 0;

    // reset in the middle of a data transaction
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80; plan_delay = 0;
    tick();
    bus.d_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk_zero("midrst");
    rst = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h204; plan_delay = 2; plan_data = 32'hCAFE0001;
    tick();
    bus.if_req = 1'b0;
    repeat (4) tick();

    // randomized traffic
    spur = 1;
    repeat (800) begin
      if (acc_i || !bus.if_req) begin
        bus.if_req  = ($urandom_range(0, 2) != 0);
        bus.if_addr = $urandom;
      end
      if (acc_d || !bus.d_req) begin
        bus.d_req   = ($urandom_range(0, 2) != 0);
        bus.d_we    = $urandom_range(0, 1) == 1;
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
      end
      r = $urandom_range(0, 11);
      if (r == 0)      plan_delay = 0;
      else if (r == 1) plan_delay = TO;
      else if (r == 2) plan_delay = TO - 1;
      else             plan_delay = $urandom_range(1, 3);
      plan_data = $urandom;
      tick();
    end
    spur = 0;
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    repeat (TO + 4) tick();
    chk("sb_drained", sb.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
